// File: rtl/pmd901_capture_pkg.sv
// pmd901_capture_pkg: record kinds, frame states and field widths shared by the capture engine
package pmd901_capture_pkg;
  typedef enum logic [1:0] {K_PARK, K_BEND, K_FRAME, K_FRAME_ERR} rec_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} frame_state_e;
  localparam int REC_BITS_W = 6;
endpackage

// File: rtl/pmd901_frame_capture_if.sv
// pmd901_frame_capture_if: valid/ready record stream out of the capture engine
interface pmd901_frame_capture_if import pmd901_capture_pkg::*; #(parameter int DATA_W = 16);
  logic rec_valid;
  logic rec_ready;
  logic [1:0] rec_kind;
  logic rec_park;
  logic rec_bend;
  logic [DATA_W-1:0] rec_speed;
  logic [REC_BITS_W-1:0] rec_bits;
  modport master(output rec_valid, rec_kind, rec_park, rec_bend, rec_speed, rec_bits, input rec_ready);
  modport slave(input rec_valid, rec_kind, rec_park, rec_bend, rec_speed, rec_bits, output rec_ready);
endinterface

// File: rtl/pmd901_rec_fifo.sv
// pmd901_rec_fifo: width/depth FIFO with valid/ready read port and same-cycle push/pop when full
module pmd901_rec_fifo #(
  parameter int W = 26,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic [W-1:0] din,
  output logic full,
  output logic valid,
  input  logic ready,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic pop, wen;
  assign valid = wr != rd;
  assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign pop = valid && ready;
  assign wen = push && (!full || pop);
  assign dout = valid ? mem[rd[AW-1:0]] : '0;
  always_ff @(posedge clk)
    if (wen) mem[wr[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (!rstn) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (wen) wr <= wr + (AW+1)'(1);
      if (pop) rd <= rd + (AW+1)'(1);
    end
endmodule

// File: rtl/pmd901_frame_capture.sv
// pmd901_frame_capture: PMD901 pin observer emitting PARK/BEND/FRAME records; PMD901_FRAME_CHECK_EN marks wrong-length frames FRAME_ERR
module pmd901_frame_capture import pmd901_capture_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic csn,
  input  logic sclk,
  input  logic mosi,
  input  logic park,
  input  logic bend,
  pmd901_frame_capture_if.master rec,
  output logic [DROP_W-1:0] drop_cnt
);
  // s1/s2 bit order: {bend, park, mosi, sclk, csn}; p keeps previous csn, sclk, park, bend
  logic [4:0] s1, s2;
  logic [3:0] p;
  logic [1:0] prime;
  logic primed, csn_fall, csn_rise, sclk_rise, park_evt, bend_evt, frame_evt;
  frame_state_e state, nxt;
  logic [DATA_W-1:0] shift_reg, frame_speed;
  logic [REC_BITS_W-1:0] bit_cnt, frame_bits;
  logic pend_park, pend_frame, pend_bend, full, can_push;
  logic go_park, go_frame, go_bend;
  logic [1:0] drop_inc;
  logic [DROP_W:0] drop_sum;
  rec_kind_e frame_kind, kind;
  logic [DATA_W+9:0] din, dout;
  always_ff @(posedge clk)
    if (!rstn) begin
      s1 <= 5'b00001;
      s2 <= 5'b00001;
      p <= 4'b0001;
      prime <= '0;
    end else begin
      s1 <= {bend, park, mosi, sclk, csn};
      s2 <= s1;
      p <= {s2[4:3], s2[1:0]};
      prime <= primed ? prime : prime + 2'd1;
    end
  assign primed = &prime;
  assign csn_fall = primed & p[0] & ~s2[0];
  assign csn_rise = primed & ~p[0] & s2[0];
  assign sclk_rise = primed & ~p[1] & s2[1];
  assign park_evt = primed & (p[2] ^ s2[3]);
  assign bend_evt = primed & (p[3] ^ s2[4]) & s2[0];
  assign frame_evt = state == S_DONE;
  always_ff @(posedge clk)
    if (!rstn) state <= S_IDLE;
    else state <= nxt;
  // a park drop mid-frame aborts the frame even if csn rises on the same cycle
  always_comb begin
    nxt = S_IDLE;
    if (state == S_IDLE) nxt = csn_fall && s2[3] ? S_SHIFT : S_IDLE;
    else if (state == S_SHIFT) nxt = park_evt && !s2[3] ? S_IDLE : csn_rise ? S_DONE : S_SHIFT;
  end
`ifdef PMD901_FRAME_CHECK_EN
  assign frame_kind = frame_bits != REC_BITS_W'(DATA_W) ? K_FRAME_ERR : K_FRAME;
`else
  assign frame_kind = K_FRAME;
`endif
  assign can_push = !full || (rec.rec_valid && rec.rec_ready);
  assign go_park = pend_park & can_push;
  assign go_frame = pend_frame & ~pend_park & can_push;
  assign go_bend = pend_bend & ~pend_park & ~pend_frame & can_push;
  assign kind = go_park ? K_PARK : go_frame ? frame_kind : K_BEND;
  assign din = {kind, s2[3], s2[4], go_frame ? frame_bits : '0, go_frame ? frame_speed : '0};
  assign drop_inc = 2'(park_evt & pend_park & ~go_park) + 2'(frame_evt & pend_frame & ~go_frame)
                  + 2'(bend_evt & pend_bend & ~go_bend);
  assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(drop_inc);
  always_ff @(posedge clk)
    if (!rstn) begin
      pend_park <= 1'b0;
      pend_frame <= 1'b0;
      pend_bend <= 1'b0;
      frame_speed <= '0;
      frame_bits <= '0;
      shift_reg <= '0;
      bit_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      pend_park <= park_evt | (pend_park & ~go_park);
      pend_frame <= frame_evt | (pend_frame & ~go_frame);
      pend_bend <= bend_evt | (pend_bend & ~go_bend);
      if (frame_evt) begin
        frame_speed <= shift_reg;
        frame_bits <= bit_cnt;
      end
      if (state == S_IDLE && nxt == S_SHIFT) begin
        shift_reg <= '0;
        bit_cnt <= '0;
      end else if (state == S_SHIFT && sclk_rise && !csn_rise) begin
        shift_reg <= {shift_reg[DATA_W-2:0], s2[2]};
        bit_cnt <= &bit_cnt ? bit_cnt : bit_cnt + REC_BITS_W'(1);
      end
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  pmd901_rec_fifo #(.W(DATA_W + 10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(go_park | go_frame | go_bend),
    .din(din),
    .full(full),
    .valid(rec.rec_valid),
    .ready(rec.rec_ready),
    .dout(dout)
  );
  assign {rec.rec_kind, rec.rec_park, rec.rec_bend, rec.rec_bits, rec.rec_speed} = dout;
endmodule

// File: tb/tb_pmd901_frame_capture.sv
// tb_pmd901_frame_capture: directed stimulus with a record scoreboard for pmd901_frame_capture
module tb_pmd901_frame_capture;
  typedef struct packed {
    logic [1:0] kind;
    logic park;
    logic bend;
    logic [5:0] bits;
    logic [15:0] speed;
  } rec_t;
`ifdef PMD901_FRAME_CHECK_EN
  localparam logic [1:0] SHORT_K = 2'd3;
`else
  localparam logic [1:0] SHORT_K = 2'd2;
`endif
  logic clk = 1'b0, rstn = 1'b0, csn = 1'b1, sclk = 1'b0, mosi = 1'b0, park = 1'b0, bend = 1'b0;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  rec_t sb[$];
  pmd901_frame_capture_if #(.DATA_W(16)) bus ();
  pmd901_frame_capture #(.DATA_W(16), .FIFO_DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .rstn(rstn), .csn(csn), .sclk(sclk), .mosi(mosi),
    .park(park), .bend(bend), .rec(bus.master), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic expect_rec(input logic [1:0] k, input logic pk, input logic bd, input logic [5:0] bits,
                            input logic [15:0] speed);
    sb.push_back('{kind: k, park: pk, bend: bd, bits: bits, speed: speed});
  endtask
  task automatic spi_frame(input logic [31:0] value, input int nbits);
    csn = 1'b0;
    tick(3);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = value[i];
      tick(3);
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
    end
    tick(3);
    csn = 1'b1;
    tick(10);
  endtask
  always @(negedge clk)
    if (rstn && bus.rec_valid && bus.rec_ready) begin
      rec_t got, exp;
      got = '{kind: bus.rec_kind, park: bus.rec_park, bend: bus.rec_bend, bits: bus.rec_bits, speed: bus.rec_speed};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got kind=%0d park=%0b bend=%0b bits=%0d speed=%0h expected none",
                 got.kind, got.park, got.bend, got.bits, got.speed);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL record: got kind=%0d park=%0b bend=%0b bits=%0d speed=%0h expected kind=%0d park=%0b bend=%0b bits=%0d speed=%0h",
                   got.kind, got.park, got.bend, got.bits, got.speed,
                   exp.kind, exp.park, exp.bend, exp.bits, exp.speed);
        end
      end
    end
  initial begin
    bus.rec_ready = 1'b1;
    tick(4);
    chk("reset_valid", 32'(bus.rec_valid), 0);
    chk("reset_kind", 32'(bus.rec_kind), 0);
    chk("reset_park", 32'(bus.rec_park), 0);
    chk("reset_bend", 32'(bus.rec_bend), 0);
    chk("reset_speed", 32'(bus.rec_speed), 0);
    chk("reset_bits", 32'(bus.rec_bits), 0);
    chk("reset_drop", 32'(drop_cnt), 0);
    rstn = 1'b1;
    tick(6);
    spi_frame(32'h1234, 16);
    chk("unpowered_no_record", 32'(sb.size()), 0);
    park = 1'b1;
    expect_rec(2'd0, 1'b1, 1'b0, 6'd0, 16'h0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("latency_edge2_valid", 32'(bus.rec_valid), 0);
    @(posedge clk); #1;
    chk("latency_edge3_valid", 32'(bus.rec_valid), 1);
    tick(6);
    expect_rec(2'd2, 1'b1, 1'b0, 6'd16, 16'hA5C3);
    spi_frame(32'hA5C3, 16);
    expect_rec(SHORT_K, 1'b1, 1'b0, 6'd12, 16'h0ABC);
    spi_frame(32'hABC, 12);
    csn = 1'b0;
    tick(5);
    bend = 1'b1;
    tick(6);
    bend = 1'b0;
    tick(6);
    csn = 1'b1;
    expect_rec(SHORT_K, 1'b1, 1'b0, 6'd0, 16'h0);
    tick(10);
    bend = 1'b1;
    expect_rec(2'd1, 1'b1, 1'b1, 6'd0, 16'h0);
    tick(10);
    park = 1'b0;
    bend = 1'b0;
    expect_rec(2'd0, 1'b0, 1'b0, 6'd0, 16'h0);
    expect_rec(2'd1, 1'b0, 1'b0, 6'd0, 16'h0);
    tick(10);
    park = 1'b1;
    expect_rec(2'd0, 1'b1, 1'b0, 6'd0, 16'h0);
    tick(10);
    csn = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      tick(3);
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
    end
    park = 1'b0;
    expect_rec(2'd0, 1'b0, 1'b0, 6'd0, 16'h0);
    tick(8);
    csn = 1'b1;
    tick(10);
    chk("abort_drained", 32'(sb.size()), 0);
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bend = ~bend;
      tick(6);
    end
    tick(6);
    chk("bp_drop", 32'(drop_cnt), 1);
    chk("bp_head_kind", 32'(bus.rec_kind), 1);
    chk("bp_head_bend", 32'(bus.rec_bend), 1);
    for (int i = 0; i < 4; i++) expect_rec(2'd1, 1'b0, i[0] ? 1'b0 : 1'b1, 6'd0, 16'h0);
    expect_rec(2'd1, 1'b0, 1'b0, 6'd0, 16'h0);
    bus.rec_ready = 1'b1;
    tick(20);
    chk("bp_drained", 32'(sb.size()), 0);
    park = 1'b1;
    expect_rec(2'd0, 1'b1, 1'b0, 6'd0, 16'h0);
    tick(10);
    csn = 1'b0;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      tick(3);
      sclk = 1'b1;
      tick(3);
      sclk = 1'b0;
    end
    rstn = 1'b0;
    tick(4);
    rstn = 1'b1;
    tick(8);
    csn = 1'b1;
    tick(10);
    chk("reset_midframe_drop", 32'(drop_cnt), 0);
    expect_rec(2'd2, 1'b1, 1'b0, 6'd16, 16'h00FF);
    spi_frame(32'h00FF, 16);
    tick(10);
    chk("final_queue_empty", 32'(sb.size()), 0);
    chk("final_valid", 32'(bus.rec_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
